pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised, flow-controlled pipeline stage register. Next generation of the fixed-width IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Replaces the global stall/flush wires with a valid/ready handshake on each side.
- Holds a 2-entry skid buffer, so upstream ready is a registered signal with no combinational path from downstream ready.
- Squashes invalid or flushed slots to a NOP bubble: instruction = NOP_INSTR, control = 0, data = 0.

Parameters:
- INSTR_W, 16: instruction field width.
- DATA_W, 72: packed payload width (pc, ReadData1, ReadData2, Imm, rd/rs/rt).
- CTRL_W, 13: packed control-signal width.
- NOP_INSTR, 16'h4000: instruction value presented when the output slot is a bubble.

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all held entries and the current input.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  INSTR_W  instruction.
- in_ctrl  in  CTRL_W  control bits.
- in_data  in  DATA_W  payload.
- out_valid  out  1  output slot holds a live instruction.
- out_ready  in  1  downstream accepts (~stall).
- out_instr  out  INSTR_W  instruction, or NOP_INSTR when !out_valid.
- out_ctrl  out  CTRL_W  control, or 0 when !out_valid.
- out_data  out  DATA_W  payload, or 0 when !out_valid.

Behaviour:
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Data held in a slot never changes while that slot is valid and not transferred.
- Storage: main slot (drives outputs) and skid slot. State is one of EMPTY, ONE or TWO.
- in_ready is registered and equals !skid_valid. It is 1 in EMPTY and ONE, 0 in TWO.
- Transitions, evaluated each rising clk edge when rst=0 and flush=0:
  - EMPTY: in_valid -> ONE, main <= in. Otherwise stay EMPTY.
  - ONE:
    - out_ready & in_valid -> ONE, main <= in (back-to-back, 1 instr/cycle).
    - out_ready & !in_valid -> EMPTY.
    - !out_ready & in_valid -> TWO, skid <= in.
    - Neither -> stay ONE.
  - TWO: out_ready -> ONE, main <= skid. Otherwise stay TWO. Input is ignored because in_ready=0.
- Latency:
  - 1 cycle from input transfer to out_valid when the stage was EMPTY, or when it was ONE with out_ready=1.
  - Throughput is 1 per cycle with no bubbles while out_ready=1.
- flush:
  - Next state is EMPTY, both valid bits cleared, in_ready=1.
  - An input presented in the flush cycle is discarded even if in_valid=1.
  - flush takes priority over every transition.
  - Slot data registers may keep stale values, but outputs are squashed.
- rst: same effect as flush; additionally, slot data registers are cleared to 0.
- Reset values: out_valid=0, in_ready=1, out_instr=NOP_INSTR, out_ctrl=0, out_data=0.
- Output squash is a combinational mux on main_valid. No other combinational input-to-output paths exist.
- Simultaneous events:
  - rst > flush > handshake.
  - In ONE with out_ready=1 and in_valid=1, the pop and the push happen in the same edge.
- Reset or flush mid-stall, in state TWO: both entries are dropped and the next state is EMPTY.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_bubble_cnt[31:0].
  - perf_stall_cnt increments each cycle with out_valid & !out_ready.
  - perf_bubble_cnt increments each cycle with !out_valid & !rst.
  - Both counters saturate at 32'hFFFF_FFFF.
  - rst clears both counters; flush does not.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - NOP_INSTR_DEFAULT = 16'h4000.
  - Stage state enum {ST_EMPTY, ST_ONE, ST_TWO}.
  - Default widths INSTR_W_DEFAULT, CTRL_W_DEFAULT.
- Sub-module pipe_slot:
  - One register entry holding {valid, instr, ctrl, data}.
  - Inputs: wen, clr, d. Output: q.
  - Instantiated twice (main, skid).
  - Successor of the existing pldff.

Test Plan:
- Reset: assert rst 2 cycles -> out_valid=0, out_instr=16'h4000, out_ctrl=0, out_data=0, in_ready=1.
- Streaming: out_ready=1, push instrs 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> they appear on out_instr on cycles 1, 2, 3 after the first push; out_valid high for 3 cycles, no gaps.
- Skid fill: push 16'hA001, then hold out_ready=0 and push 16'hA002 -> state TWO; in_ready=0 on the next cycle; 16'hA003 is held off upstream. Release out_ready -> outputs A001, then A002, then A003 in order, with nothing lost or duplicated.
- Flush in TWO: fill both slots, assert flush with in_valid=1 and in_instr=16'hBEEF -> next cycle out_valid=0, out_instr=16'h4000, in_ready=1; BEEF never appears.
- Hold stability: out_ready=0 for 5 cycles with out_valid=1 -> out_instr, out_ctrl and out_data are bit-identical on all 5 cycles.
- With PIPE_STAGE_PERF_EN defined: run 3 stall cycles and 4 bubble cycles -> perf_stall_cnt=3, perf_bubble_cnt=4. Preload near saturation via force -> counter holds at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and state encoding for the flow-controlled pipeline stages.
package pipe_pkg;
    localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h4000;
    localparam int INSTR_W_DEFAULT = 16;
    localparam int CTRL_W_DEFAULT = 13;
    localparam int DATA_W_DEFAULT = 72;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} stage_state_e;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one stage register entry {valid, instr, ctrl, data}; valid is the MSB.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] q_q, q_d;
    // clr only drops valid; payload may stay stale because outputs are squashed
    always_comb q_d = clr ? {1'b0, q_q[W-2:0]} : wen ? d : q_q;
    always_ff @(posedge clk) begin
        if (rst) q_q <= '0;
        else     q_q <= q_d;
    end
    assign q = q_q;
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage with 2-entry skid buffer and NOP squash.
// Optional perf counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int CTRL_W  = CTRL_W_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [CTRL_W-1:0]  in_ctrl,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [CTRL_W-1:0]  out_ctrl,
    output logic [DATA_W-1:0]  out_data
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_bubble_cnt
`endif
);
    localparam int SW = 1 + INSTR_W + CTRL_W + DATA_W;
    stage_state_e state_q, state_d;
    logic [SW-1:0] main_q, skid_q, main_d, in_word;
    logic main_wen, main_clr, skid_wen, skid_clr;
    assign in_word = {1'b1, in_instr, in_ctrl, in_data};
    always_comb begin
        state_d  = state_q;
        main_wen = 1'b0;
        main_clr = 1'b0;
        skid_wen = 1'b0;
        skid_clr = 1'b0;
        main_d   = in_word;
        case (state_q)
            ST_EMPTY: if (in_valid) begin
                main_wen = 1'b1;
                state_d  = ST_ONE;
            end
            ST_ONE: if (out_ready && in_valid) begin
                main_wen = 1'b1;
            end else if (out_ready) begin
                main_clr = 1'b1;
                state_d  = ST_EMPTY;
            end else if (in_valid) begin
                skid_wen = 1'b1;
                state_d  = ST_TWO;
            end
            ST_TWO: if (out_ready) begin
                main_wen = 1'b1;
                main_d   = skid_q;
                skid_clr = 1'b1;
                state_d  = ST_ONE;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
            state_d  = ST_EMPTY;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end
    pipe_slot #(.W(SW)) u_main (
        .clk(clk), .rst(rst), .wen(main_wen), .clr(main_clr), .d(main_d), .q(main_q)
    );
    pipe_slot #(.W(SW)) u_skid (
        .clk(clk), .rst(rst), .wen(skid_wen), .clr(skid_clr), .d(in_word), .q(skid_q)
    );
    // skid valid is a flop, so in_ready never sees out_ready combinationally
    assign in_ready  = ~skid_q[SW-1];
    assign out_valid = main_q[SW-1];
    assign out_instr = out_valid ? main_q[SW-2 -: INSTR_W] : NOP_INSTR;
    assign out_ctrl  = out_valid ? main_q[DATA_W +: CTRL_W] : '0;
    assign out_data  = out_valid ? main_q[DATA_W-1:0] : '0;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_bubble_q, perf_bubble_d;
    always_comb begin
        perf_stall_d  = (out_valid && !out_ready && perf_stall_q != '1) ? perf_stall_q + 32'd1 : perf_stall_q;
        perf_bubble_d = (!out_valid && perf_bubble_q != '1) ? perf_bubble_q + 32'd1 : perf_bubble_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end
    assign perf_stall_cnt  = perf_stall_q;
    assign perf_bubble_cnt = perf_bubble_q;
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: table-driven directed bench for pipe_stage_skid.
module tb_pipe_stage_skid;
    logic clk = 1'b0, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_instr, out_instr;
    logic [12:0] in_ctrl, out_ctrl;
    logic [71:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_cnt, perf_bubble_cnt;
`endif
    int n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_skid dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    typedef struct {
        logic        fl;
        logic        iv;
        logic [15:0] instr;
        logic        ordy;
        logic        ev;
        logic        er;
        logic [15:0] ei;
    } vec_t;
    vec_t vecs[16];

    function automatic logic [12:0] ctrl_of(input logic [15:0] i);
        return 13'(i ^ 16'h1234);
    endfunction
    function automatic logic [71:0] data_of(input logic [15:0] i);
        return {i, 8'h5A, ~i, 8'hC3, i, i};
    endfunction

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic ev, input logic er, input logic [15:0] ei);
        chk({name, ".out_valid"}, 72'(out_valid), 72'(ev));
        chk({name, ".in_ready"}, 72'(in_ready), 72'(er));
        chk({name, ".out_instr"}, 72'(out_instr), 72'(ev ? ei : 16'h4000));
        chk({name, ".out_ctrl"}, 72'(out_ctrl), 72'(ev ? ctrl_of(ei) : 13'h0));
        chk({name, ".out_data"}, out_data, ev ? data_of(ei) : 72'h0);
    endtask

    task automatic drive(input logic r, input logic fl, input logic iv, input logic [15:0] i, input logic ordy);
        @(negedge clk);
        rst = r;
        flush = fl;
        in_valid = iv;
        in_instr = i;
        in_ctrl = ctrl_of(i);
        in_data = data_of(i);
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b1, 16'h1111};
        vecs[1]  = '{1'b0, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 16'h2222};
        vecs[2]  = '{1'b0, 1'b1, 16'h3333, 1'b1, 1'b1, 1'b1, 16'h3333};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000};
        vecs[4]  = '{1'b0, 1'b1, 16'hA001, 1'b0, 1'b1, 1'b1, 16'hA001};
        vecs[5]  = '{1'b0, 1'b1, 16'hA002, 1'b0, 1'b1, 1'b0, 16'hA001};
        vecs[6]  = '{1'b0, 1'b1, 16'hA003, 1'b0, 1'b1, 1'b0, 16'hA001};
        vecs[7]  = '{1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b1, 16'hA002};
        vecs[8]  = '{1'b0, 1'b1, 16'hA003, 1'b1, 1'b1, 1'b1, 16'hA003};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000};
        vecs[10] = '{1'b0, 1'b1, 16'hC001, 1'b0, 1'b1, 1'b1, 16'hC001};
        vecs[11] = '{1'b0, 1'b1, 16'hC002, 1'b0, 1'b1, 1'b0, 16'hC001};
        vecs[12] = '{1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'h4000};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h4000};
        vecs[14] = '{1'b0, 1'b1, 16'hD001, 1'b1, 1'b1, 1'b1, 16'hD001};
        vecs[15] = '{1'b1, 1'b1, 16'hD002, 1'b1, 1'b0, 1'b1, 16'h4000};

        drive(1'b1, 1'b0, 1'b1, 16'h7777, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 16'h7777, 1'b0);
        chk_out("reset", 1'b0, 1'b1, 16'h4000);

        foreach (vecs[i])
            begin
                drive(1'b0, vecs[i].fl, vecs[i].iv, vecs[i].instr, vecs[i].ordy);
                chk_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].ei);
            end

        drive(1'b0, 1'b0, 1'b1, 16'hE001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
            chk_out($sformatf("hold%0d", k), 1'b1, 1'b1, 16'hE001);
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk_out("hold_drain", 1'b0, 1'b1, 16'h4000);

        drive(1'b0, 1'b0, 1'b1, 16'hF001, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 16'hF002, 1'b0);
        chk_out("rst_two_fill", 1'b1, 1'b0, 16'hF001);
        drive(1'b1, 1'b0, 1'b1, 16'hF003, 1'b0);
        chk_out("rst_two", 1'b0, 1'b1, 16'h4000);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk_out("rst_two_after", 1'b0, 1'b1, 16'h4000);

`ifdef PIPE_STAGE_PERF_EN
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("perf_rst_stall", 72'(perf_stall_cnt), 72'd0);
        chk("perf_rst_bubble", 72'(perf_bubble_cnt), 72'd0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 16'h9001, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("perf_stall", 72'(perf_stall_cnt), 72'd3);
        chk("perf_bubble", 72'(perf_bubble_cnt), 72'd4);
        @(negedge clk);
        force dut.perf_stall_q = 32'hFFFF_FFFE;
        #1 release dut.perf_stall_q;
        for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("perf_stall_sat", 72'(perf_stall_cnt), 72'hFFFF_FFFF);
        chk("perf_bubble_hold", 72'(perf_bubble_cnt), 72'd4);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
